// File: rtl/oled_spi_master_if.sv
// rtl/oled_spi_master_if.sv - word handshake between the OLED sequencer and oled_spi_master
interface oled_spi_master_if #(
  parameter int DATA_W = 8
);
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_DC;
  logic              TX_LAST;

  modport master (output TX_VALID, TX_DATA, TX_DC, TX_LAST, input TX_READY);
  modport slave  (input TX_VALID, TX_DATA, TX_DC, TX_LAST, output TX_READY);
endinterface

// File: rtl/oled_spi_master.sv
// rtl/oled_spi_master.sv - write-only OLED SPI master with burst holding register
module oled_spi_master #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 40,
  parameter bit CPOL      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_GAP    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  oled_spi_master_if.slave tx,
  output logic             BUSY,
  output logic             DONE,
  output logic             SCLK,
  output logic             CS,
  output logic             DC,
  output logic             DIN
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_LOW, S_HIGH} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_dc_q, hold_dc_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic              last_q, last_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              dc_q, dc_d;
  logic              din_q, din_d;
  logic              done_q, done_d;

  logic              accept, load, load_from_hold;
  logic [DATA_W-1:0] ld_data, next_shift;
  logic              ld_dc, ld_last;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign next_shift = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0} : {1'b0, shift_q[DATA_W-1:1]};

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    gap_d          = gap_q;
    shift_d        = shift_q;
    hold_data_d    = hold_data_q;
    hold_dc_d      = hold_dc_q;
    hold_last_d    = hold_last_q;
    hold_full_d    = hold_full_q;
    last_d         = last_q;
    cs_d           = cs_q;
    sclk_d         = sclk_q;
    dc_d           = dc_q;
    din_d          = din_q;
    done_d         = 1'b0;
    accept         = tx.TX_VALID && !hold_full_q;
    load           = 1'b0;
    load_from_hold = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load           = 1'b1;
          load_from_hold = 1'b1;
        end else if (accept) begin
          load = 1'b1;
        end
      end
      S_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            done_d = 1'b1;
            // Burst only continues if the next word is already waiting.
            if (!last_q && hold_full_q) begin
              load           = 1'b1;
              load_from_hold = 1'b1;
            end else begin
              cs_d    = 1'b1;
              sclk_d  = CPOL;
              gap_d   = '0;
              state_d = S_GAP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = next_shift;
            din_d   = first_bit(next_shift);
            sclk_d  = 1'b0;
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ld_data = load_from_hold ? hold_data_q : tx.TX_DATA;
    ld_dc   = load_from_hold ? hold_dc_q   : tx.TX_DC;
    ld_last = load_from_hold ? hold_last_q : tx.TX_LAST;

    if (load) begin
      state_d = S_LOW;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      dc_d    = ld_dc;
      last_d  = ld_last;
      shift_d = ld_data;
      din_d   = first_bit(ld_data);
      div_d   = '0;
      bit_d   = '0;
    end

    if (load_from_hold) hold_full_d = 1'b0;

    // A word taken straight off the bus in IDLE bypasses the holding register.
    if (accept && !(load && !load_from_hold)) begin
      hold_data_d = tx.TX_DATA;
      hold_dc_d   = tx.TX_DC;
      hold_last_d = tx.TX_LAST;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      shift_q     <= '0;
      hold_data_q <= '0;
      hold_dc_q   <= 1'b0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      last_q      <= 1'b0;
      cs_q        <= 1'b1;
      sclk_q      <= CPOL;
      dc_q        <= 1'b0;
      din_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      hold_data_q <= hold_data_d;
      hold_dc_q   <= hold_dc_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      cs_q        <= cs_d;
      sclk_q      <= sclk_d;
      dc_q        <= dc_d;
      din_q       <= din_d;
      done_q      <= done_d;
    end
  end

  assign tx.TX_READY = !hold_full_q;
  assign BUSY        = (state_q != S_IDLE) || hold_full_q;
  assign DONE        = done_q;
  assign SCLK        = sclk_q;
  assign CS          = cs_q;
  assign DC          = dc_q;
  assign DIN         = din_q;
endmodule

// File: tb/tb_oled_spi_master.sv
// tb/tb_oled_spi_master.sv - randomized self-checking bench for oled_spi_master
module tb_oled_spi_master;
  localparam int W0 = 8;
  localparam int H0 = 2;
  localparam int G0 = 2;
  localparam int W1 = 9;
  localparam int H1 = 3;
  localparam int G1 = 3;

  function automatic int cw(input int d); return (d == 0) ? W0 : W1; endfunction
  function automatic int ch(input int d); return (d == 0) ? H0 : H1; endfunction
  function automatic int cg(input int d); return (d == 0) ? G0 : G1; endfunction
  function automatic logic cpol(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction
  function automatic logic cmsb(input int d); return (d == 0) ? 1'b1 : 1'b0; endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        drv_rst   [2];
  logic        drv_valid [2];
  logic [31:0] drv_data  [2];
  logic        drv_dc    [2];
  logic        drv_last  [2];

  logic busy0, done0, sclk0, cs0, dc0, din0, rdy0;
  logic busy1, done1, sclk1, cs1, dc1, din1, rdy1;

  oled_spi_master_if #(.DATA_W(W0)) if0 ();
  oled_spi_master_if #(.DATA_W(W1)) if1 ();

  assign if0.TX_VALID = drv_valid[0];
  assign if0.TX_DATA  = drv_data[0][W0-1:0];
  assign if0.TX_DC    = drv_dc[0];
  assign if0.TX_LAST  = drv_last[0];
  assign rdy0         = if0.TX_READY;
  assign if1.TX_VALID = drv_valid[1];
  assign if1.TX_DATA  = drv_data[1][W1-1:0];
  assign if1.TX_DC    = drv_dc[1];
  assign if1.TX_LAST  = drv_last[1];
  assign rdy1         = if1.TX_READY;

  oled_spi_master #(.DATA_W(W0), .CLK_DIV(H0), .CPOL(1'b0), .MSB_FIRST(1'b1), .CS_GAP(G0)) dut0 (
    .CLK(clk), .RST(drv_rst[0]), .tx(if0), .BUSY(busy0), .DONE(done0),
    .SCLK(sclk0), .CS(cs0), .DC(dc0), .DIN(din0));
  oled_spi_master #(.DATA_W(W1), .CLK_DIV(H1), .CPOL(1'b1), .MSB_FIRST(1'b0), .CS_GAP(G1)) dut1 (
    .CLK(clk), .RST(drv_rst[1]), .tx(if1), .BUSY(busy1), .DONE(done1),
    .SCLK(sclk1), .CS(cs1), .DC(dc1), .DIN(din1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word schedule expressed as start cycles and frame arithmetic.
  longint      cyc = 0;
  bit          m_active [2], m_hold_v [2], m_acc [2];
  bit          m_cur_dc [2], m_cur_last [2], m_hold_dc [2], m_hold_last [2];
  logic [31:0] m_cur_data [2], m_hold_data [2];
  longint      m_start [2], m_gap_until [2], m_done_at [2];
  logic [31:0] exp_buf [2][256];
  int          exp_wr [2], exp_rd [2];

  logic o_cs [2], o_sclk [2], o_din [2], o_dc [2], o_done [2], o_busy [2], o_rdy [2];
  bit          cmp_en = 1'b0;
  bit          prev_sclk [2];
  logic [31:0] cap [2];
  int          nb [2], rise_cnt [2], done_cnt [2], frame_cnt [2], frame_len [2];
  int          low_run [2], hi_run [2], hi_len [2], hist_n [2], acc_cnt [2];
  longint      last_done [2], done_gap [2];
  logic [31:0] hist [2][128];

  task automatic chk(input string name, input int d, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%b expected=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input int d, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_load(input int d, input logic [31:0] data, input bit dc, input bit last);
    m_cur_data[d] = data;
    m_cur_dc[d]   = dc;
    m_cur_last[d] = last;
    m_active[d]   = 1'b1;
    m_start[d]    = cyc;
  endtask

  task automatic model_step(input int d);
    longint      span;
    logic [31:0] mask;
    bit          took;
    span = 2 * longint'(ch(d)) * longint'(cw(d));
    mask = (32'h1 << cw(d)) - 32'h1;
    took = 1'b0;
    m_acc[d] = 1'b0;
    if (drv_rst[d]) begin
      m_active[d] = 1'b0; m_hold_v[d] = 1'b0;
      m_gap_until[d] = cyc; m_done_at[d] = -1;
      return;
    end
    m_acc[d] = drv_valid[d] && !m_hold_v[d];
    if (m_active[d] && cyc == m_start[d] + span) begin
      m_done_at[d] = cyc;
      exp_buf[d][exp_wr[d] % 256] = m_cur_data[d];
      exp_wr[d]++;
      if (!m_cur_last[d] && m_hold_v[d]) begin
        model_load(d, m_hold_data[d], m_hold_dc[d], m_hold_last[d]);
        m_hold_v[d] = 1'b0;
      end else begin
        m_active[d] = 1'b0;
        m_gap_until[d] = cyc + cg(d);
      end
    end else if (!m_active[d] && cyc >= m_gap_until[d] + 1) begin
      if (m_hold_v[d]) begin
        model_load(d, m_hold_data[d], m_hold_dc[d], m_hold_last[d]);
        m_hold_v[d] = 1'b0;
      end else if (m_acc[d]) begin
        model_load(d, drv_data[d] & mask, drv_dc[d], drv_last[d]);
        took = 1'b1;
      end
    end
    if (m_acc[d] && !took) begin
      m_hold_data[d] = drv_data[d] & mask;
      m_hold_dc[d]   = drv_dc[d];
      m_hold_last[d] = drv_last[d];
      m_hold_v[d]    = 1'b1;
    end
  endtask

  task automatic compare_dut(input int d);
    longint h, o;
    int     b;
    logic   e_sclk, e_din;
    h = longint'(ch(d));
    chk("ready", d, o_rdy[d], !m_hold_v[d]);
    chk("busy", d, o_busy[d], m_active[d] || (cyc < m_gap_until[d]) || m_hold_v[d]);
    chk("done", d, o_done[d], m_done_at[d] == cyc);
    if (m_active[d]) begin
      o = cyc - m_start[d];
      b = int'(o / (2 * h));
      e_sclk = (o % (2 * h)) >= h;
      e_din = cmsb(d) ? m_cur_data[d][cw(d)-1-b] : m_cur_data[d][b];
      chk("cs", d, o_cs[d], 1'b0);
      chk("sclk", d, o_sclk[d], e_sclk);
      chk("din", d, o_din[d], e_din);
      chk("dc", d, o_dc[d], m_cur_dc[d]);
    end else begin
      chk("cs", d, o_cs[d], 1'b1);
      chk("sclk_idle", d, o_sclk[d], cpol(d));
    end
  endtask

  task automatic monitor(input int d);
    if (o_done[d] === 1'b1) begin
      n_checks++;
      if (exp_rd[d] == exp_wr[d]) begin
        n_errors++;
        $display("FAIL scoreboard dut%0d cyc=%0d actual=%0h expected=none", d, cyc, cap[d]);
      end else begin
        n_checks--;
        chk_val("scoreboard", d, cap[d], exp_buf[d][exp_rd[d] % 256]);
        exp_rd[d]++;
      end
      if (hist_n[d] < 128) begin hist[d][hist_n[d]] = cap[d]; hist_n[d]++; end
      done_gap[d] = cyc - last_done[d];
      last_done[d] = cyc;
      done_cnt[d]++;
      cap[d] = '0; nb[d] = 0;
    end
    if (o_sclk[d] === 1'b1 && !prev_sclk[d] && o_cs[d] === 1'b0) begin
      if (cmsb(d)) cap[d] = {cap[d][30:0], o_din[d]};
      else cap[d][nb[d]] = o_din[d];
      nb[d]++; rise_cnt[d]++;
    end
    if (o_cs[d] !== 1'b0) begin
      cap[d] = '0; nb[d] = 0;
      if (low_run[d] > 0) begin frame_len[d] = low_run[d]; frame_cnt[d]++; end
      low_run[d] = 0; hi_run[d]++;
    end else begin
      if (hi_run[d] > 0) hi_len[d] = hi_run[d];
      hi_run[d] = 0; low_run[d]++;
    end
    prev_sclk[d] = (o_sclk[d] === 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      o_cs[0] = cs0;   o_sclk[0] = sclk0; o_din[0] = din0; o_dc[0] = dc0;
      o_done[0] = done0; o_busy[0] = busy0; o_rdy[0] = rdy0;
      o_cs[1] = cs1;   o_sclk[1] = sclk1; o_din[1] = din1; o_dc[1] = dc1;
      o_done[1] = done1; o_busy[1] = busy1; o_rdy[1] = rdy1;
      if (cmp_en) for (int d = 0; d < 2; d++) begin compare_dut(d); monitor(d); end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] data, input logic dc, input logic last,
                      input bit scramble);
    bit ok;
    ok = 1'b0;
    drv_valid[d] = 1'b1; drv_data[d] = data; drv_dc[d] = dc; drv_last[d] = last;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (m_acc[d]) begin ok = 1'b1; break; end
      if (scramble) drv_data[d] = $urandom;
    end
    if (ok) acc_cnt[d]++;
    else begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout dut%0d actual=not_accepted expected=accepted", d);
    end
  endtask

  // kind 0: idle, 1: done_cnt >= target, 2: rise_cnt >= target
  task automatic wait_for(input int d, input int kind, input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (kind == 0 && o_busy[d] === 1'b0 && drv_valid[d] == 1'b0) ok = 1'b1;
      if (kind == 1 && done_cnt[d] >= target) ok = 1'b1;
      if (kind == 2 && rise_cnt[d] >= target) ok = 1'b1;
      if (ok) break;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL wait_timeout dut%0d kind=%0d actual=timeout expected=event", d, kind);
    end
  endtask

  int h0, f0, dn0, a0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      drv_rst[d] = 1'b1; drv_valid[d] = 1'b0; drv_data[d] = '0;
      drv_dc[d] = 1'b0; drv_last[d] = 1'b0; m_done_at[d] = -1;
    end
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_cs0", 0, cs0, 1'b1);     chk("rst_sclk0", 0, sclk0, 1'b0);
    chk("rst_sclk1", 1, sclk1, 1'b1); chk("rst_din0", 0, din0, 1'b0);
    chk("rst_dc0", 0, dc0, 1'b0);     chk("rst_rdy0", 0, rdy0, 1'b1);
    chk("rst_busy1", 1, busy1, 1'b0); chk("rst_done1", 1, done1, 1'b0);
    drv_rst[0] = 1'b0; drv_rst[1] = 1'b0;
    tick();

    // single word, MSB first
    h0 = hist_n[0]; f0 = frame_cnt[0]; dn0 = done_cnt[0];
    send(0, 32'hA5, 1'b1, 1'b1, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 0, 0, 400);
    chk_val("t1_word", 0, hist[0][h0], 32'hA5);
    chk_val("t1_cs_len", 0, frame_len[0], 32);
    chk_val("t1_dones", 0, done_cnt[0] - dn0, 1);
    chk_val("t1_frames", 0, frame_cnt[0] - f0, 1);

    // two-word burst
    h0 = hist_n[0]; f0 = frame_cnt[0];
    send(0, 32'hAE, 1'b0, 1'b0, 1'b0);
    send(0, 32'h3C, 1'b1, 1'b1, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 0, 0, 400);
    chk_val("t2_word0", 0, hist[0][h0], 32'hAE);
    chk_val("t2_word1", 0, hist[0][h0+1], 32'h3C);
    chk_val("t2_cs_len", 0, frame_len[0], 64);
    chk_val("t2_done_gap", 0, done_gap[0], 32);
    chk_val("t2_frames", 0, frame_cnt[0] - f0, 1);

    // non-LAST word with nothing queued ends the frame
    h0 = hist_n[0]; f0 = frame_cnt[0];
    send(0, 32'h11, 1'b0, 1'b0, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 1, done_cnt[0] + 1, 400);
    repeat (10) tick();
    send(0, 32'h22, 1'b1, 1'b1, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 0, 0, 400);
    chk_val("t3_word0", 0, hist[0][h0], 32'h11);
    chk_val("t3_word1", 0, hist[0][h0+1], 32'h22);
    chk_val("t3_frames", 0, frame_cnt[0] - f0, 2);
    chk_val("t3_cs_len", 0, frame_len[0], 32);
    chk("t3_gap_min", 0, hi_len[0] >= G0, 1'b1);

    // 9-bit, CPOL=1, LSB first
    h0 = hist_n[1];
    send(1, 32'h101, 1'b1, 1'b1, 1'b0); drv_valid[1] = 1'b0;
    wait_for(1, 0, 0, 600);
    chk_val("t4_word", 1, hist[1][h0], 32'h101);
    chk_val("t4_cs_len", 1, frame_len[1], 54);
    chk("t4_sclk_idle", 1, sclk1, 1'b1);

    // reset mid-word
    dn0 = done_cnt[0];
    send(0, 32'hC3, 1'b1, 1'b1, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 2, rise_cnt[0] + 3, 200);
    drv_rst[0] = 1'b1;
    tick();
    drv_rst[0] = 1'b0;
    chk("t5_cs", 0, cs0, 1'b1);     chk("t5_sclk", 0, sclk0, 1'b0);
    chk("t5_rdy", 0, rdy0, 1'b1);   chk("t5_done", 0, done0, 1'b0);
    chk("t5_busy", 0, busy0, 1'b0); chk("t5_din", 0, din0, 1'b0);
    repeat (40) tick();
    chk_val("t5_no_done", 0, done_cnt[0] - dn0, 0);
    h0 = hist_n[0];
    send(0, 32'h5A, 1'b0, 1'b1, 1'b0); drv_valid[0] = 1'b0;
    wait_for(0, 0, 0, 400);
    chk_val("t5_word", 0, hist[0][h0], 32'h5A);
    chk_val("t5_cs_len", 0, frame_len[0], 32);

    // random bursts with TX_VALID held and TX_DATA churning while not ready
    for (int d = 0; d < 2; d++) begin
      dn0 = done_cnt[d]; a0 = acc_cnt[d];
      for (int k = 0; k < 30; k++) begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++)
          send(d, $urandom, 1'($urandom), (j == n - 1) || ($urandom_range(0, 7) == 0), 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          drv_valid[d] = 1'b0;
          repeat ($urandom_range(0, 20)) tick();
        end
      end
      drv_valid[d] = 1'b0;
      wait_for(d, 0, 0, 2000);
      chk_val("t6_words", d, done_cnt[d] - dn0, acc_cnt[d] - a0);
      chk_val("t6_drained", d, exp_wr[d] - exp_rd[d], 0);
    end

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/oled_spi_master.md
Name: oled_spi_master

Overview:
Parametrised successor to the OLED single-byte SPI writer. It is a write-only SPI master with a programmable SCLK divider, word width, clock polarity and bit order. A one-entry holding register and valid/ready input allow multi-word bursts with CS held low, and DC is latched per word. It sits between the OLED command/data sequencer and the panel pins CS, DC, SCLK and DIN.

Parameters:
DATA_W, 8, bits per word; legal range 2..32.
CLK_DIV, 40, SCLK half-period in CLK cycles (H); must be >= 1.
CPOL, 0, SCLK idle level; slave always samples on SCLK rising edge.
MSB_FIRST, 1, 1 = shift out MSB first, 0 = LSB first.
CS_GAP, 2, minimum CLK cycles CS stays high between transfers; must be >= 1.

Ports:
CLK  input  1  system clock.
RST  input  1  synchronous, active-high reset.
TX_VALID  input  1  word offered.
TX_READY  output  1  holding register can accept a word.
TX_DATA  input  DATA_W  word to send.
TX_DC  input  1  DC level for this word (0 = command, 1 = data).
TX_LAST  input  1  deassert CS after this word.
BUSY  output  1  engine active or holding register full.
DONE  output  1  one-cycle pulse at the end of each word.
SCLK  output  1  serial clock to panel.
CS  output  1  chip select, active low.
DC  output  1  data/command to panel.
DIN  output  1  serial data to panel.

Behaviour:
- Reset (sync, RST=1 at posedge): next cycle CS=1, SCLK=CPOL, DIN=0, DC=0, DONE=0, BUSY=0, TX_READY=1. Holding register, shifter and counters are cleared. A word in flight is abandoned with no DONE pulse. This applies mid-word as well.
- All panel outputs and DONE are registered.
- TX_READY = !hold_full. It depends only on state, never on TX_VALID.
- Accept: TX_VALID && TX_READY at a posedge latches {TX_DATA, TX_DC, TX_LAST}. TX_DATA is ignored while TX_READY=0.
- States: IDLE, GAP, LOW (SCLK low phase, DIN valid), HIGH (SCLK high phase).
- IDLE -> LOW: when a word is available (holding register, or a direct bypass in the accept cycle).
  - On entry, CS=0, DC=word DC, DIN=first bit, SCLK=0.
  - Outputs change the cycle after accept, so latency from accept to CS low is 1 cycle.
- LOW: lasts H cycles, then SCLK=1 -> HIGH. This rising edge is the sampling edge.
- HIGH: lasts H cycles.
  - If bits remain: SCLK=0, DIN=next bit -> LOW.
  - After bit DATA_W (end of word): DONE pulses for 1 cycle, then:
    - Word not LAST and holding register full: burst. The next word loads, CS stays 0, DC updates, SCLK=0, DIN=first bit -> LOW.
    - Otherwise: CS=1, SCLK=CPOL -> GAP.
- A word without LAST and with an empty holding register still ends the transfer. CS is never held low waiting for data.
- GAP: lasts CS_GAP cycles with CS=1, then -> IDLE. A word accepted during GAP waits in the holding register.
- CPOL=1: SCLK sits high in IDLE/GAP. It falls with CS assertion and rises/falls exactly as above. After the last word it returns high with CS deassert.
- Word timing from CS low to DONE: 2*H*DATA_W cycles. A burst of N words keeps CS low for 2*H*DATA_W*N cycles.
- Bit order: MSB_FIRST=1 sends bit DATA_W-1 down to bit 0; MSB_FIRST=0 sends bit 0 up to bit DATA_W-1.
- BUSY = (state != IDLE) || hold_full.
- Counter widths: $clog2 of CLK_DIV, DATA_W and CS_GAP. No wrap is permitted beyond the terminal counts.
- Simultaneous events:
  - Accept in the same cycle the engine pulls from the holding register: the new word lands; no loss, no duplication.
  - RST has priority over everything.

Test Plan:
1. DATA_W=8, CLK_DIV=2, CPOL=0, MSB_FIRST=1: send 0xA5 with DC=1, LAST=1 -> CS low 32 cycles; 8 rising SCLK edges sample DIN 1,0,1,0,0,1,0,1; DC=1 throughout; one DONE; CS high; BUSY low after 2 GAP cycles.
2. Burst: 0xAE (DC=0, LAST=0) then 0x3C (DC=1, LAST=1) offered back-to-back -> CS low for a continuous 64 cycles; 16 rising edges; DC switches to 1 at the low phase of bit 9; two DONE pulses 32 cycles apart.
3. 0x11 with LAST=0, then 0x22 offered 10 cycles after DONE -> CS returns high after the first word and stays high >= CS_GAP cycles; two separate CS frames with correct bits.
4. DATA_W=9, CPOL=1, MSB_FIRST=0, send 0x101 -> SCLK idles high; DIN sampled on rising edges = 1,0,0,0,0,0,0,0,1; SCLK high again after CS deassert.
5. Assert RST for 1 cycle after the 3rd rising edge of a word -> next cycle CS=1, SCLK=CPOL, TX_READY=1, no DONE; a following 0x5A transmits cleanly.
6. Hold TX_VALID high with changing TX_DATA during a burst -> TX_READY drops while the holding register is full; only accepted words appear on DIN, in order, none lost or duplicated.
